rob_multiport: RTL

Parametrised reorder buffer that supersedes the fixed 2-wide ROB. It has configurable depth, dispatch width and commit width, explicit writeback completion ports, and real flush recovery with tail rollback and selective invalidation. It sits between rename/dispatch and the commit path (free-list release, LSQ retire). Pointers increment, and each carries an extra phase bit that serves as the age/sorting bit for downstream structures.

---
 rtl/rob_multiport.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rob_multiport.sv
// Reorder buffer: multi-slot dispatch, writeback completion, in-order commit, flush with tail rollback.
// Allocation and commit are combinational from state; updates land on the next edge.
module rob_multiport #(
   parameter int ROB_DEPTH   = 64,
   parameter int ROB_SEL     = 6,
   parameter int DISP_W      = 2,
   parameter int COMMIT_W    = 2,
   parameter int WB_PORTS    = 3,
   parameter int REG_SEL     = 5,
   parameter int PHY_REG_SEL = 6
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [DISP_W-1:0]               disp_valid,
   input  logic [DISP_W-1:0]               disp_is_load,
   input  logic [DISP_W-1:0]               disp_is_store,
   input  logic [DISP_W*REG_SEL-1:0]       disp_dst,
   input  logic [DISP_W*PHY_REG_SEL-1:0]   disp_ori_tag,
   input  logic                            stall_DP,
   output logic                            allocatable,
   output logic [DISP_W*ROB_SEL-1:0]       disp_rob_idx,
   output logic [DISP_W-1:0]               disp_rob_phase,
   input  logic [WB_PORTS-1:0]             wb_valid,
   input  logic [WB_PORTS*ROB_SEL-1:0]     wb_rob_idx,
   input  logic                            flush_valid,
   input  logic [ROB_SEL-1:0]              flush_rob_idx,
   input  logic                            flush_incl,
   output logic [COMMIT_W-1:0]             commit_valid,
   output logic [COMMIT_W-1:0]             commit_is_load,
   output logic [COMMIT_W-1:0]             commit_is_store,
   output logic [COMMIT_W*REG_SEL-1:0]     commit_dst,
   output logic [COMMIT_W*PHY_REG_SEL-1:0] commit_release_tag,
   output logic                            empty,
   output logic                            full
);
   localparam int PW = ROB_SEL + 1;
   localparam logic [PW:0] DEPTH_EXT = ROB_DEPTH[PW:0];

   logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
   logic [ROB_DEPTH-1:0]   valid_q, valid_d, complete_q, complete_d;
   logic [ROB_DEPTH-1:0]   is_load_q, is_load_d, is_store_q, is_store_d;
   logic [REG_SEL-1:0]     dst_q [ROB_DEPTH];
   logic [REG_SEL-1:0]     dst_d [ROB_DEPTH];
   logic [PHY_REG_SEL-1:0] tag_q [ROB_DEPTH];
   logic [PHY_REG_SEL-1:0] tag_d [ROB_DEPTH];

   logic [PW-1:0]          count, disp_cnt, flush_cnt, commit_lim, commit_cnt;
   logic [PW:0]            free_cnt;
   logic [ROB_SEL-1:0]     head_idx, flush_off;
   logic [ROB_DEPTH-1:0]   kill;
   logic [PW-1:0]          disp_ptr [DISP_W];
   logic [ROB_SEL-1:0]     cidx [COMMIT_W];
   logic                   fire, chain;

   assign head_idx    = head_q[ROB_SEL-1:0];
   assign count       = tail_q - head_q;
   assign free_cnt    = DEPTH_EXT - {1'b0, count};
   assign empty       = (count == '0);
   assign full        = (count == DEPTH_EXT[PW-1:0]);
   assign allocatable = ({1'b0, disp_cnt} <= free_cnt);
   assign fire        = ~stall_DP & allocatable & ~flush_valid;

   // Surviving age span after a flush; commits in the flush cycle are capped by it too.
   assign flush_off  = flush_rob_idx - head_idx;
   assign flush_cnt  = {1'b0, flush_off} + {{ROB_SEL{1'b0}}, ~flush_incl};
   assign commit_lim = flush_valid ? flush_cnt : count;

   always_comb begin
      disp_cnt = '0;
      for (int k = 0; k < DISP_W; k++) disp_cnt = disp_cnt + PW'(disp_valid[k]);
   end

   for (genvar k = 0; k < DISP_W; k++) begin : g_alloc
      assign disp_ptr[k] = tail_q + PW'(k);
      assign disp_rob_idx[k*ROB_SEL +: ROB_SEL] = disp_ptr[k][ROB_SEL-1:0];
      assign disp_rob_phase[k] = disp_ptr[k][ROB_SEL];
   end

   for (genvar k = 0; k < COMMIT_W; k++) begin : g_commit
      assign cidx[k] = head_idx + ROB_SEL'(k);
      assign commit_is_load[k]  = is_load_q[cidx[k]];
      assign commit_is_store[k] = is_store_q[cidx[k]];
      assign commit_dst[k*REG_SEL +: REG_SEL] = dst_q[cidx[k]];
      assign commit_release_tag[k*PHY_REG_SEL +: PHY_REG_SEL] = tag_q[cidx[k]];
   end

   always_comb begin
      commit_valid = '0;
      commit_cnt   = '0;
      chain        = 1'b1;
      for (int k = 0; k < COMMIT_W; k++) begin
         chain = chain & (PW'(k) < commit_lim) & valid_q[cidx[k]] & complete_q[cidx[k]];
         commit_valid[k] = chain;
         commit_cnt = commit_cnt + PW'(chain);
      end
   end

   always_comb begin
      kill = '0;
      for (int i = 0; i < ROB_DEPTH; i++)
         kill[i] = flush_valid & ({1'b0, ROB_SEL'(i) - head_idx} >= flush_cnt);
   end

   always_comb begin
      head_d     = head_q + commit_cnt;
      tail_d     = tail_q;
      valid_d    = valid_q;
      complete_d = complete_q;
      is_load_d  = is_load_q;
      is_store_d = is_store_q;
      dst_d      = dst_q;
      tag_d      = tag_q;
      for (int p = 0; p < WB_PORTS; p++)
         if (wb_valid[p] && valid_q[wb_rob_idx[p*ROB_SEL +: ROB_SEL]])
            complete_d[wb_rob_idx[p*ROB_SEL +: ROB_SEL]] = 1'b1;
      // Kill after writeback so a completion racing the flush is dropped.
      valid_d    = valid_d & ~kill;
      complete_d = complete_d & ~kill;
      for (int k = 0; k < COMMIT_W; k++)
         if (commit_valid[k]) begin
            valid_d[cidx[k]]    = 1'b0;
            complete_d[cidx[k]] = 1'b0;
         end
      if (flush_valid) begin
         tail_d = head_q + flush_cnt;
      end else if (fire) begin
         for (int k = 0; k < DISP_W; k++)
            if (disp_valid[k]) begin
               valid_d[disp_ptr[k][ROB_SEL-1:0]]    = 1'b1;
               complete_d[disp_ptr[k][ROB_SEL-1:0]] = 1'b0;
               is_load_d[disp_ptr[k][ROB_SEL-1:0]]  = disp_is_load[k];
               is_store_d[disp_ptr[k][ROB_SEL-1:0]] = disp_is_store[k];
               dst_d[disp_ptr[k][ROB_SEL-1:0]] = disp_dst[k*REG_SEL +: REG_SEL];
               tag_d[disp_ptr[k][ROB_SEL-1:0]] = disp_ori_tag[k*PHY_REG_SEL +: PHY_REG_SEL];
            end
         tail_d = tail_q + disp_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         valid_q    <= '0;
         complete_q <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         valid_q    <= valid_d;
         complete_q <= complete_d;
      end
      is_load_q  <= is_load_d;
      is_store_q <= is_store_d;
      dst_q      <= dst_d;
      tag_q      <= tag_d;
   end
endmodule
